// File: rtl/ipdc_pkg.sv
// Shared definitions for the ipdc command feeder: op modes, sequencer states
// and pixel/image geometry.
package ipdc_pkg;

    localparam int PIX_W      = 24;
    localparam int IMG_PIXELS = 64;
    localparam int WIN_PIXELS = 16;

    localparam logic [2:0] OP_LOAD    = 3'd0;
    localparam logic [2:0] OP_RIGHT   = 3'd1;
    localparam logic [2:0] OP_DOWN    = 3'd2;
    localparam logic [2:0] OP_DEFAULT = 3'd3;
    localparam logic [2:0] OP_ZOOM    = 3'd4;
    localparam logic [2:0] OP_MEDIAN  = 3'd5;
    localparam logic [2:0] OP_YCBCR   = 3'd6;
    localparam logic [2:0] OP_RGB     = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_LOAD,
        ST_WAIT_DONE,
        ST_WAIT_DISP
    } state_e;

    // Shift/zoom ops return a display window; filter/colour ops only finish.
    function automatic state_e issue_next(input logic [2:0] mode);
        if (mode == OP_LOAD)
            return ST_LOAD;
        else if (mode <= OP_ZOOM)
            return ST_WAIT_DISP;
        else
            return ST_WAIT_DONE;
    endfunction

endpackage

// File: rtl/ipdc_cmd_fifo.sv
// Small synchronous FIFO for queued op modes. A push while full is accepted
// only when a pop frees a slot in the same cycle.
module ipdc_cmd_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign o_full  = (count_q == (AW+1)'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_data  = mem_q[rd_ptr_q];

    assign pop_ok  = i_pop && !o_empty;
    assign push_ok = i_push && (!o_full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok)
            rd_ptr_d = rd_ptr_q + AW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ipdc_cmd_feeder.sv
// Sequencer in front of ipdc: queues host op modes, issues them one at a time,
// streams load pixels, collects display windows and guards every wait with a timeout.
module ipdc_cmd_feeder
    import ipdc_pkg::*;
#(
    parameter int CMD_DEPTH  = 4,
    parameter int IMG_PIXELS = ipdc_pkg::IMG_PIXELS,
    parameter int WIN_PIXELS = ipdc_pkg::WIN_PIXELS,
    parameter int TIMEOUT    = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    input  logic [2:0]       i_cmd_mode,
    output logic             o_cmd_ready,
    input  logic             i_pix_valid,
    input  logic [PIX_W-1:0] i_pix_data,
    output logic             o_pix_ready,
    output logic             o_op_valid,
    output logic [2:0]       o_op_mode,
    output logic             o_in_valid,
    output logic [PIX_W-1:0] o_in_data,
    input  logic             i_in_ready,
    input  logic             i_out_valid,
    input  logic [PIX_W-1:0] i_out_data,
    output logic             o_win_valid,
    output logic [PIX_W-1:0] o_win_data,
    output logic             o_win_last,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    localparam int AW  = $clog2(CMD_DEPTH);
    localparam int WCW = $clog2(WIN_PIXELS + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [2:0]       cur_mode_q, cur_mode_d;
    logic [6:0]       pix_cnt_q, pix_cnt_d;
    logic [WCW-1:0]   win_cnt_q, win_cnt_d;
    logic [TCW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             win_valid_q, win_valid_d;
    logic             win_last_q, win_last_d;
    logic [PIX_W-1:0] win_data_q, win_data_d;

    logic             fifo_pop, fifo_full, fifo_empty;
    logic [2:0]       fifo_head;
    logic [AW:0]      fifo_count;
    logic             in_load, xfer, waiting, progress;

    ipdc_cmd_fifo #(
        .WIDTH (3),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_cmd_valid),
        .i_data  (i_cmd_mode),
        .i_pop   (fifo_pop),
        .o_data  (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    assign in_load  = (state_q == ST_LOAD);
    assign xfer     = in_load && i_pix_valid && i_in_ready;
    assign waiting  = in_load || (state_q == ST_WAIT_DONE) || (state_q == ST_WAIT_DISP);
    assign progress = xfer || (i_out_valid &&
                      ((state_q == ST_WAIT_DONE) || (state_q == ST_WAIT_DISP)));

    always_comb begin
        state_d     = state_q;
        cur_mode_d  = cur_mode_q;
        pix_cnt_d   = pix_cnt_q;
        win_cnt_d   = win_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        err_d       = err_q;
        done_d      = 1'b0;
        win_valid_d = 1'b0;
        win_last_d  = 1'b0;
        win_data_d  = '0;
        fifo_pop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    cur_mode_d = fifo_head;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = issue_next(cur_mode_q);
            end
            ST_LOAD: begin
                if (xfer) begin
                    tmo_cnt_d = '0;
                    if (pix_cnt_q == 7'(IMG_PIXELS - 1)) begin
                        pix_cnt_d = '0;
                        state_d   = ST_WAIT_DONE;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 7'd1;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (i_out_valid) begin
                    tmo_cnt_d = '0;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_WAIT_DISP: begin
                if (i_out_valid) begin
                    tmo_cnt_d   = '0;
                    win_valid_d = 1'b1;
                    win_data_d  = i_out_data;
                    if (win_cnt_q == WCW'(WIN_PIXELS - 1)) begin
                        win_last_d = 1'b1;
                        done_d     = 1'b1;
                        win_cnt_d  = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        win_cnt_d = win_cnt_q + WCW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A stalled wait abandons the command; queued commands stay queued.
        if (waiting && !progress) begin
            if (tmo_cnt_q == TCW'(TIMEOUT - 1)) begin
                err_d     = 1'b1;
                state_d   = ST_IDLE;
                pix_cnt_d = '0;
                win_cnt_d = '0;
                tmo_cnt_d = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TCW'(1);
            end
        end

        // ipdc output while nothing is expected from it is a protocol violation.
        if (i_out_valid && ((state_q == ST_IDLE) || (state_q == ST_ISSUE) || in_load))
            err_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cur_mode_q  <= '0;
            pix_cnt_q   <= '0;
            win_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            win_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cur_mode_q  <= cur_mode_d;
            pix_cnt_q   <= pix_cnt_d;
            win_cnt_q   <= win_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            err_q       <= err_d;
            done_q      <= done_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
            win_data_q  <= win_data_d;
        end
    end

    assign o_cmd_ready = !fifo_full;
    assign o_pix_ready = in_load && i_in_ready;
    assign o_in_valid  = xfer;
    assign o_in_data   = in_load ? i_pix_data : '0;
    assign o_op_valid  = (state_q == ST_ISSUE);
    assign o_op_mode   = (state_q == ST_ISSUE) ? cur_mode_q : 3'd0;
    assign o_win_valid = win_valid_q;
    assign o_win_data  = win_data_q;
    assign o_win_last  = win_last_q;
    assign o_busy      = (state_q != ST_IDLE) || (fifo_count != '0);
    assign o_done      = done_q;
    assign o_err       = err_q;

endmodule
